// File: rtl/cmd_queue_pkg.sv
// Shared types and defaults for the command queue and its round-robin arbiter.
// cmd_t is the native command word; CMD_W defaults to its width.
package cmd_queue_pkg;

  typedef struct packed {
    logic [2:0] opcode;
    logic [4:0] operand;
  } cmd_t;

  localparam int CMDQ_DEPTH_DFLT = 16;
  localparam int CMDQ_NCH_DFLT   = 2;

  // Index width that stays legal for a single-channel build.
  function automatic int cmdq_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmdq_rr_arb.sv
// Round-robin grant among NCH requesters; search starts one past the last grant.
// Channel 0 has first priority out of reset.
module cmdq_rr_arb
  import cmd_queue_pkg::*;
#(
  parameter int NCH = CMDQ_NCH_DFLT,
  localparam int IDX_W = cmdq_idx_w(NCH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [NCH-1:0]   i_req,
  input  logic             i_en,
  output logic [NCH-1:0]   o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_vld
);

  logic [IDX_W-1:0] r_start;

  always_comb begin
    int c;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    c         = 0;
    for (int k = 0; k < NCH; k++) begin
      c = int'(r_start) + k;
      if (c >= NCH) c = c - NCH;
      if (i_en && !o_gnt_vld && i_req[c]) begin
        o_gnt[c]  = 1'b1;
        o_gnt_idx = IDX_W'(c);
        o_gnt_vld = 1'b1;
      end
    end
  end

  // A grant always completes a push, so the pointer moves on every grant.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_start <= '0;
    end else if (o_gnt_vld) begin
      r_start <= (o_gnt_idx == IDX_W'(NCH - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_queue.sv
// Multi-producer command FIFO with round-robin push arbitration and a registered
// show-ahead head. Define CMD_QUEUE_STATS_EN to build the push/pop/high-water counters.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int CMD_W = $bits(cmd_t),
  parameter int DEPTH = CMDQ_DEPTH_DFLT,
  parameter int NCH   = CMDQ_NCH_DFLT
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [NCH-1:0]             i_push_valid,
  input  logic [NCH*CMD_W-1:0]       i_push_cmd,
  output logic [NCH-1:0]             o_push_ready,
  input  logic                       i_flush,
  output logic [CMD_W-1:0]           queue_cmd,
  output logic                       queue_empty,
  input  logic                       issuer_rd_queue,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_underflow,
  output logic                       o_idle,
  output logic [31:0]                o_push_cnt,
  output logic [31:0]                o_pop_cnt,
  output logic [31:0]                o_max_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = cmdq_idx_w(NCH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CMD_W-1:0] r_queue_cmd;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [CMD_W-1:0] w_push_data;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_nxt_idx;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  cmdq_rr_arb #(.NCH(NCH)) u_arb (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_req     (i_push_valid),
    .i_en      (!w_full && !i_flush),
    .o_gnt     (o_push_ready),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_push)
  );

  assign w_push_data  = i_push_cmd[w_gnt_idx*CMD_W +: CMD_W];
  assign w_pop        = issuer_rd_queue && !w_empty && !i_flush;
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
  assign w_wr_idx     = r_wr_ptr[AW-1:0];
  assign w_rd_nxt_idx = w_rd_ptr_nxt[AW-1:0];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[w_wr_idx] <= w_push_data;
  end

  // Head register bypasses the array when the new head is the word being written.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_queue_cmd <= '0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_count_nxt != '0) begin
        r_queue_cmd <= (w_push && (w_wr_idx == w_rd_nxt_idx)) ? w_push_data : r_mem[w_rd_nxt_idx];
      end
      if (issuer_rd_queue && w_empty) r_underflow <= 1'b1;
    end
  end

  assign queue_cmd   = r_queue_cmd;
  assign queue_empty = w_empty;
  assign o_count     = r_count;
  assign o_underflow = r_underflow;
  assign o_idle      = w_empty && !(|i_push_valid);

`ifdef CMD_QUEUE_STATS_EN
  logic [31:0] r_push_cnt;
  logic [31:0] r_pop_cnt;
  logic [31:0] r_max_level;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_push_cnt  <= '0;
      r_pop_cnt   <= '0;
      r_max_level <= '0;
    end else begin
      if (w_push && (r_push_cnt != '1)) r_push_cnt <= r_push_cnt + 1'b1;
      if (w_pop && (r_pop_cnt != '1))   r_pop_cnt  <= r_pop_cnt + 1'b1;
      if (32'(w_count_nxt) > r_max_level) r_max_level <= 32'(w_count_nxt);
    end
  end

  assign o_push_cnt  = r_push_cnt;
  assign o_pop_cnt   = r_pop_cnt;
  assign o_max_level = r_max_level;
`else
  assign o_push_cnt  = '0;
  assign o_pop_cnt   = '0;
  assign o_max_level = '0;
`endif

endmodule

// File: tb/tb_cmd_queue.sv
// Scoreboard bench for cmd_queue: the driver keeps a queue-level reference model and
// pushes expected popped words; a negedge monitor compares DUT outputs against it.
module tb_cmd_queue;
  import cmd_queue_pkg::*;

  localparam int CMD_W = $bits(cmd_t);
  localparam int DEPTH = 16;
  localparam int NCH   = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef CMD_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NCH-1:0]       i_push_valid = '0;
  logic [NCH*CMD_W-1:0] i_push_cmd = '0;
  logic [NCH-1:0]       o_push_ready;
  logic                 i_flush = 1'b0;
  logic [CMD_W-1:0]     queue_cmd;
  logic                 queue_empty;
  logic                 issuer_rd_queue = 1'b0;
  logic [CNT_W-1:0]     o_count;
  logic                 o_underflow;
  logic                 o_idle;
  logic [31:0]          o_push_cnt;
  logic [31:0]          o_pop_cnt;
  logic [31:0]          o_max_level;

  always #5 clk = ~clk;

  cmd_queue #(.CMD_W(CMD_W), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_push_valid   (i_push_valid),
    .i_push_cmd     (i_push_cmd),
    .o_push_ready   (o_push_ready),
    .i_flush        (i_flush),
    .queue_cmd      (queue_cmd),
    .queue_empty    (queue_empty),
    .issuer_rd_queue(issuer_rd_queue),
    .o_count        (o_count),
    .o_underflow    (o_underflow),
    .o_idle         (o_idle),
    .o_push_cnt     (o_push_cnt),
    .o_pop_cnt      (o_pop_cnt),
    .o_max_level    (o_max_level)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [CMD_W-1:0] mq[$];
  logic [CMD_W-1:0] sb[$];
  int  rr_last = NCH - 1;
  bit  m_uflow = 1'b0;
  int  m_push_cnt = 0, m_pop_cnt = 0, m_max = 0;

  // expectations for the current cycle, read by the monitor
  bit              mon_en = 1'b0;
  int              e_count;
  bit              e_empty, e_uflow, e_idle;
  logic [NCH-1:0]  e_gnt;
  logic [CMD_W-1:0] e_head;
  int              e_push_cnt, e_pop_cnt, e_max;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*CMD_W-1:0] rnd_cmds();
    logic [NCH*CMD_W-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c*CMD_W +: CMD_W] = CMD_W'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    rr_last    = NCH - 1;
    m_uflow    = 1'b0;
    m_push_cnt = 0;
    m_pop_cnt  = 0;
    m_max      = 0;
  endtask

  // Drive one cycle of stimulus, publish expectations, advance the model past the edge.
  task automatic step(input logic [NCH-1:0] v, input logic [NCH*CMD_W-1:0] cmds,
                      input bit fl, input bit pop);
    int g;
    g = -1;
    i_push_valid    = v;
    i_push_cmd      = cmds;
    i_flush         = fl;
    issuer_rd_queue = pop;

    e_count    = mq.size();
    e_empty    = (mq.size() == 0);
    e_head     = (mq.size() > 0) ? mq[0] : '0;
    e_uflow    = m_uflow;
    e_idle     = e_empty && (v == '0);
    e_push_cnt = STATS ? m_push_cnt : 0;
    e_pop_cnt  = STATS ? m_pop_cnt : 0;
    e_max      = STATS ? m_max : 0;
    e_gnt      = '0;
    if (!fl && mq.size() < DEPTH) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (rr_last + k) % NCH;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g >= 0) e_gnt[g] = 1'b1;

    if (fl) begin
      mq.delete();
    end else begin
      if (pop) begin
        if (mq.size() > 0) begin
          sb.push_back(mq.pop_front());
          m_pop_cnt++;
        end else begin
          m_uflow = 1'b1;
        end
      end
      if (g >= 0) begin
        mq.push_back(cmds[g*CMD_W +: CMD_W]);
        rr_last = g;
        m_push_cnt++;
      end
    end
    if (mq.size() > m_max) m_max = mq.size();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit pop);
    step('0, '0, 1'b0, pop);
  endtask

  task automatic drain();
    for (int i = 0; i < 2*DEPTH && mq.size() > 0; i++) idle_cycle(1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count",     32'(o_count),      32'(e_count));
      chk("empty",     32'(queue_empty),  32'(e_empty));
      chk("ready",     32'(o_push_ready), 32'(e_gnt));
      chk("underflow", 32'(o_underflow),  32'(e_uflow));
      chk("idle",      32'(o_idle),       32'(e_idle));
      chk("push_cnt",  o_push_cnt,        32'(e_push_cnt));
      chk("pop_cnt",   o_pop_cnt,         32'(e_pop_cnt));
      chk("max_level", o_max_level,       32'(e_max));
      if (!e_empty) chk("head", 32'(queue_cmd), 32'(e_head));
      if (issuer_rd_queue && !queue_empty && !i_flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_data: actual=%0h required=none (no pop expected) at %0t", queue_cmd, $time);
        end else begin
          chk("pop_data", 32'(queue_cmd), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [NCH*CMD_W-1:0] w;
    int pp;

    repeat (3) @(negedge clk);
    chk("rst_count",    32'(o_count),     32'd0);
    chk("rst_empty",    32'(queue_empty), 32'd1);
    chk("rst_queue_cmd",32'(queue_cmd),   32'd0);
    chk("rst_underflow",32'(o_underflow), 32'd0);
    chk("rst_push_cnt", o_push_cnt,       32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // single push of 0xA5 on channel 0, then pop
    w = '0;
    w[CMD_W-1:0] = CMD_W'(8'hA5);
    step(2'b01, w, 1'b0, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // fairness: both channels valid continuously
    for (int i = 0; i < 8; i++) step(2'b11, rnd_cmds(), 1'b0, 1'b0);
    drain();

    // fill to full, hold, pop 4, push 4, drain across the wrap
    for (int i = 0; i < DEPTH; i++) step(2'b01, rnd_cmds(), 1'b0, 1'b0);
    step(2'b11, rnd_cmds(), 1'b0, 1'b0);
    step(2'b11, rnd_cmds(), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
    for (int i = 0; i < 4; i++) step(2'b10, rnd_cmds(), 1'b0, 1'b0);
    idle_cycle(1'b0);
    drain();
    idle_cycle(1'b0);

    // underflow, then simultaneous push/pop at count 3
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    for (int i = 0; i < 3; i++) step(2'b01, rnd_cmds(), 1'b0, 1'b0);
    step(2'b10, rnd_cmds(), 1'b0, 1'b1);
    idle_cycle(1'b0);

    // flush with a push pending and 7 entries queued
    for (int i = 0; i < 4; i++) step(2'b11, rnd_cmds(), 1'b0, 1'b0);
    step(2'b11, rnd_cmds(), 1'b1, 1'b0);
    idle_cycle(1'b0);
    step(2'b11, rnd_cmds(), 1'b0, 1'b0);
    drain();

    // randomized traffic in phases of differing pop pressure
    for (int i = 0; i < 1500; i++) begin
      case ((i / 250) % 3)
        0:       pp = 15;
        1:       pp = 85;
        default: pp = 50;
      endcase
      step(NCH'($urandom_range(0, 3)), rnd_cmds(),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < pp));
    end

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(2'b11, rnd_cmds(), 1'b0, 1'b0);
    mon_en = 1'b0;
    i_push_valid = '0;
    i_flush = 1'b0;
    issuer_rd_queue = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_count",     32'(o_count),     32'd0);
    chk("arst_empty",     32'(queue_empty), 32'd1);
    chk("arst_queue_cmd", 32'(queue_cmd),   32'd0);
    chk("arst_underflow", 32'(o_underflow), 32'd0);
    chk("arst_pop_cnt",   o_pop_cnt,        32'd0);
    chk("arst_max_level", o_max_level,      32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) step(2'b11, rnd_cmds(), 1'b0, 1'b0);
    drain();
    idle_cycle(1'b0);

    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
